// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM DDR deserializer.
package pdm_pkg;

  localparam int PDM_WORD_WIDTH_DEFAULT = 16;
  localparam logic [7:0] PDM_OVF_CNT_MAX = 8'd255;

  typedef enum logic {
    PDM_OUT_EMPTY = 1'b0,
    PDM_OUT_FULL  = 1'b1
  } pdm_out_state_e;

endpackage

// File: rtl/pdm_shift_packer.sv
// One channel's MSB-first shift register; the parent owns the bit counter.
module pdm_shift_packer #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift,
  input  logic                  din,
  output logic [WORD_WIDTH-1:0] word
);

  logic [WORD_WIDTH-1:0] word_q;

  // Shift the new bit in at the LSB so the first bit ends up in the MSB
  always_ff @(posedge clk) begin
    if (reset)      word_q <= '0;
    else if (shift) word_q <= {word_q[WORD_WIDTH-2:0], din};
  end

  assign word = word_q;

endmodule

// File: rtl/pdm_ddr_deserializer.sv
// Packs the rising/falling-edge PDM bit streams into two parallel words and
// holds one word pair behind a valid/ready handshake with sticky overflow.
// Optional feature macro: PDM_DESER_OVF_CNT_EN adds an 8-bit saturating
// dropped-pair counter on ovf_count.
module pdm_ddr_deserializer
  import pdm_pkg::*;
#(
  parameter int WORD_WIDTH = PDM_WORD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sample_en,
  input  logic                  q0,
  input  logic                  q1,
  output logic [WORD_WIDTH-1:0] data_ch0,
  output logic [WORD_WIDTH-1:0] data_ch1,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overflow,
  input  logic                  overflow_clr
`ifdef PDM_DESER_OVF_CNT_EN
  ,
  output logic [7:0]            ovf_count
`endif
);

  localparam int NUM_CH = 2;
  localparam int CNT_W  = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH - 1);

  logic                               shift;
  logic                               complete;
  logic                               drop;
  logic [NUM_CH-1:0]                  din_w;
  logic [NUM_CH-1:0][WORD_WIDTH-1:0]  sr_w;
  logic [NUM_CH-1:0][WORD_WIDTH-1:0]  word_d;
  logic [NUM_CH-1:0][WORD_WIDTH-1:0]  data_q;
  logic [CNT_W-1:0]                   bit_cnt_q, bit_cnt_d;
  pdm_out_state_e                     state_q;
  logic                               ovf_q;

  assign shift    = sample_en & enable;
  assign complete = shift && (bit_cnt_q == CNT_LAST);
  assign drop     = complete && (state_q == PDM_OUT_FULL) && !ready;
  assign din_w    = {q1, q0};

  // One packer per channel; the completed word includes the current bit
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pdm_shift_packer #(.WORD_WIDTH(WORD_WIDTH)) u_packer (
      .clk  (clk),
      .reset(reset),
      .shift(shift),
      .din  (din_w[c]),
      .word (sr_w[c])
    );
    assign word_d[c] = {sr_w[c][WORD_WIDTH-2:0], din_w[c]};
  end

  // Next bit position: disable restarts the word, the last bit wraps to 0
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (!enable)       bit_cnt_d = '0;
    else if (complete) bit_cnt_d = '0;
    else if (shift)    bit_cnt_d = bit_cnt_q + CNT_W'(1);
  end

  // Shared bit counter
  always_ff @(posedge clk) begin
    if (reset) bit_cnt_q <= '0;
    else       bit_cnt_q <= bit_cnt_d;
  end

  // Output holding register FSM; a drop keeps the old pair and sets the sticky flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PDM_OUT_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        PDM_OUT_EMPTY: begin
          if (complete) begin
            state_q <= PDM_OUT_FULL;
            data_q  <= word_d;
          end
        end
        PDM_OUT_FULL: begin
          if (complete && ready) data_q  <= word_d;
          else if (ready)        state_q <= PDM_OUT_EMPTY;
        end
        default: state_q <= PDM_OUT_EMPTY;
      endcase
      if (drop)              ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  assign data_ch0 = data_q[0];
  assign data_ch1 = data_q[1];
  assign valid    = (state_q == PDM_OUT_FULL);
  assign overflow = ovf_q;

`ifdef PDM_DESER_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // Saturating drop count; a drop together with a clear restarts at 1
  always_ff @(posedge clk) begin
    if (reset)                                    ovf_cnt_q <= '0;
    else if (drop && overflow_clr)                ovf_cnt_q <= 8'd1;
    else if (overflow_clr)                        ovf_cnt_q <= '0;
    else if (drop && ovf_cnt_q != PDM_OVF_CNT_MAX) ovf_cnt_q <= ovf_cnt_q + 8'd1;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_pdm_ddr_deserializer.sv
// Directed self-checking bench for pdm_ddr_deserializer (WORD_WIDTH = 16).
module tb_pdm_ddr_deserializer;

  logic        clk = 1'b0;
  logic        reset, enable, sample_en, q0, q1, ready, overflow_clr;
  logic [15:0] data_ch0, data_ch1;
  logic        valid, overflow;
`ifdef PDM_DESER_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  int vectors = 0;
  int errors  = 0;

  pdm_ddr_deserializer #(.WORD_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_en   (sample_en),
    .q0          (q0),
    .q1          (q1),
    .data_ch0    (data_ch0),
    .data_ch1    (data_ch1),
    .valid       (valid),
    .ready       (ready),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
`ifdef PDM_DESER_OVF_CNT_EN
    ,
    .ovf_count   (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; sample_en = 1'b0; q0 = 1'b0; q1 = 1'b0;
    ready = 1'b0; overflow_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Sends the top nbits of w0/w1 MSB first on back-to-back strobes.
  // rdy_last/clr_last are applied only on the 16th (completing) strobe.
  task automatic send_bits(input logic [15:0] w0, input logic [15:0] w1,
                           input int nbits, input logic rdy_last, input logic clr_last);
    logic r_save;
    r_save = ready;
    for (int i = 15; i >= 16 - nbits; i--) begin
      sample_en = 1'b1; q0 = w0[i]; q1 = w1[i];
      if (i == 0) begin
        if (rdy_last) ready = 1'b1;
        overflow_clr = clr_last;
      end
      tick();
    end
    sample_en = 1'b0; ready = r_save; overflow_clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (data_ch0 !== 16'h0) begin errors++; $display("FAIL reset_data0 got %h exp 0000", data_ch0); end
    vectors++; if (data_ch1 !== 16'h0) begin errors++; $display("FAIL reset_data1 got %h exp 0000", data_ch1); end
    vectors++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    vectors++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    ready = 1'b1;
    send_bits(16'hA5A5, 16'h0F0F, 16, 1'b0, 1'b0);
    vectors++; if (data_ch0 !== 16'hA5A5) begin errors++; $display("FAIL basic_data0 got %h exp a5a5", data_ch0); end
    vectors++; if (data_ch1 !== 16'h0F0F) begin errors++; $display("FAIL basic_data1 got %h exp 0f0f", data_ch1); end
    vectors++; if (valid !== 1'b1)        begin errors++; $display("FAIL basic_valid got %b exp 1", valid); end
    tick();
    vectors++; if (valid !== 1'b0)        begin errors++; $display("FAIL basic_valid_drop got %b exp 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    send_bits(16'h1234, 16'h5678, 16, 1'b0, 1'b0);
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_no_ovf_first got %b exp 0", overflow); end
    send_bits(16'hFFFF, 16'h0000, 16, 1'b0, 1'b0);
    vectors++; if (data_ch0 !== 16'h1234) begin errors++; $display("FAIL bp_data0 got %h exp 1234", data_ch0); end
    vectors++; if (data_ch1 !== 16'h5678) begin errors++; $display("FAIL bp_data1 got %h exp 5678", data_ch1); end
    vectors++; if (valid !== 1'b1)        begin errors++; $display("FAIL bp_valid got %b exp 1", valid); end
    vectors++; if (overflow !== 1'b1)     begin errors++; $display("FAIL bp_overflow got %b exp 1", overflow); end
`ifdef PDM_DESER_OVF_CNT_EN
    vectors++; if (ovf_count !== 8'd1)    begin errors++; $display("FAIL bp_ovf_count got %0d exp 1", ovf_count); end
`endif
  endtask

  task automatic test_accept_complete();
    do_reset();
    send_bits(16'hBEEF, 16'h1357, 16, 1'b0, 1'b0);
    send_bits(16'h2468, 16'hCAFE, 16, 1'b1, 1'b0);
    vectors++; if (valid !== 1'b1)        begin errors++; $display("FAIL ac_valid got %b exp 1", valid); end
    vectors++; if (data_ch0 !== 16'h2468) begin errors++; $display("FAIL ac_data0 got %h exp 2468", data_ch0); end
    vectors++; if (data_ch1 !== 16'hCAFE) begin errors++; $display("FAIL ac_data1 got %h exp cafe", data_ch1); end
    vectors++; if (overflow !== 1'b0)     begin errors++; $display("FAIL ac_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_midword_reset();
    do_reset();
    send_bits(16'hFFFF, 16'hFFFF, 7, 1'b0, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    send_bits(16'hC3C3, 16'h3C3C, 16, 1'b0, 1'b0);
    vectors++; if (data_ch0 !== 16'hC3C3) begin errors++; $display("FAIL mwr_data0 got %h exp c3c3", data_ch0); end
    vectors++; if (data_ch1 !== 16'h3C3C) begin errors++; $display("FAIL mwr_data1 got %h exp 3c3c", data_ch1); end
    vectors++; if (valid !== 1'b1)        begin errors++; $display("FAIL mwr_valid got %b exp 1", valid); end
  endtask

  task automatic test_midword_enable();
    do_reset();
    send_bits(16'hFFFF, 16'hFFFF, 7, 1'b0, 1'b0);
    // strobe while disabled must be ignored
    enable = 1'b0; sample_en = 1'b1; q0 = 1'b1; q1 = 1'b1; tick();
    enable = 1'b1; sample_en = 1'b0;
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL mwe_no_valid got %b exp 0", valid); end
    send_bits(16'hC3C3, 16'h5AA5, 16, 1'b0, 1'b0);
    vectors++; if (data_ch0 !== 16'hC3C3) begin errors++; $display("FAIL mwe_data0 got %h exp c3c3", data_ch0); end
    vectors++; if (data_ch1 !== 16'h5AA5) begin errors++; $display("FAIL mwe_data1 got %h exp 5aa5", data_ch1); end
    vectors++; if (valid !== 1'b1)        begin errors++; $display("FAIL mwe_valid got %b exp 1", valid); end
    // held pair still accepted while disabled
    enable = 1'b0; ready = 1'b1; tick(); ready = 1'b0; enable = 1'b1;
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL mwe_accept_disabled got %b exp 0", valid); end
  endtask

  task automatic test_clear_vs_set();
    do_reset();
    send_bits(16'h0001, 16'h0002, 16, 1'b0, 1'b0);
    send_bits(16'h0003, 16'h0004, 16, 1'b0, 1'b0);
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL cvs_set got %b exp 1", overflow); end
    send_bits(16'h0005, 16'h0006, 16, 1'b0, 1'b1);
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL cvs_set_wins got %b exp 1", overflow); end
`ifdef PDM_DESER_OVF_CNT_EN
    vectors++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL cvs_count_one got %0d exp 1", ovf_count); end
`endif
    vectors++; if (data_ch0 !== 16'h0001) begin errors++; $display("FAIL cvs_data0 got %h exp 0001", data_ch0); end
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL cvs_clear got %b exp 0", overflow); end
`ifdef PDM_DESER_OVF_CNT_EN
    vectors++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL cvs_count_clear got %0d exp 0", ovf_count); end
`endif
  endtask

`ifdef PDM_DESER_OVF_CNT_EN
  task automatic test_saturation();
    do_reset();
    send_bits(16'h1111, 16'h2222, 16, 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) send_bits(16'h3333, 16'h4444, 16, 1'b0, 1'b0);
    vectors++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", ovf_count); end
    vectors++; if (data_ch0 !== 16'h1111) begin errors++; $display("FAIL sat_data0 got %h exp 1111", data_ch0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_accept_complete();
    test_midword_reset();
    test_midword_enable();
    test_clear_vs_set();
`ifdef PDM_DESER_OVF_CNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pdm_ddr_deserializer.md
# pdm_ddr_deserializer

Consumes the two single-bit streams produced by the DDR input capture stage (Q0 captured on the rising edge, Q1 on the falling edge of the PDM clock) and packs each into parallel words. This gives two channels, as used for a stereo PDM microphone pair sharing one data line. It sits directly downstream of the DDR capture flops and feeds the decimation filter through a valid/ready handshake. It holds one output word pair and flags overflow when the consumer stalls.

## Interface
- `WORD_WIDTH`, default 16: bits per packed word, legal range 2..32.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: when low, packing stops and any partial word is discarded.
- `sample_en` input 1: one-cycle strobe, one per PDM bit period. `q0` and `q1` are stable and valid in this cycle.
- `q0` input 1: channel 0 bit from the DDR capture stage.
- `q1` input 1: channel 1 bit from the DDR capture stage.
- `data_ch0` output WORD_WIDTH: packed channel 0 word, first-received bit in the MSB.
- `data_ch1` output WORD_WIDTH: packed channel 1 word, first-received bit in the MSB.
- `valid` output 1: output word pair is held and available.
- `ready` input 1: consumer accepts the pair when `valid && ready`.
- `overflow` output 1: sticky flag; a completed word pair was dropped.
- `overflow_clr` input 1: clears `overflow`.

## Operation
- Shift registers `sr0` and `sr1` are WORD_WIDTH bits each, with a shared bit counter `bit_cnt` of width clog2(WORD_WIDTH).
- On `sample_en && enable`:
  - `sr0 <= {sr0[W-2:0], q0}` and `sr1 <= {sr1[W-2:0], q1}`.
  - `bit_cnt` increments, wrapping from W-1 to 0.
- A word completes when `sample_en && enable && bit_cnt == W-1`. The completed word is `{sr[W-2:0], q}`.
- The output register has two states:
  - EMPTY: `valid = 0`.
  - FULL: `valid = 1`.
- Transitions:
  - EMPTY + complete → FULL; load both data registers.
  - FULL + `ready` + no complete → EMPTY.
  - FULL + `ready` + complete → FULL; load the new pair. This is not an overflow.
  - FULL + `!ready` + complete → FULL; keep the old pair, drop the new pair, set `overflow`.
- `data_ch0`/`data_ch1` change only on a load and stay stable while `valid && !ready`.
- `enable` low: `bit_cnt <= 0` and shift registers are unchanged but treated as garbage. A held output pair is still presented and may still be accepted.
- `overflow`:
  - It is set by a drop and cleared by `overflow_clr`.
  - If a drop and `overflow_clr` occur in the same cycle, set wins and the flag stays 1.
- `sample_en` while `enable` is low is ignored.

## Timing
- Reset values: `data_ch0 = 0`, `data_ch1 = 0`, `valid = 0`, `overflow = 0`, `bit_cnt = 0`, state EMPTY. Reset takes priority over all inputs.
- Latency: when the completing strobe is in cycle t, `valid` and the new data appear in cycle t+1.
- Throughput: one word pair per W strobes. `sample_en` spacing is at least 1 cycle; back-to-back strobes are legal.
- Reset mid-word discards the partial word. The next word starts with the first strobe after reset deasserts.
- Nothing is combinational from input to output: `valid`, the data outputs and `overflow` are all registered.

## Configuration
- `PDM_DESER_OVF_CNT_EN`
  - **Defined:** adds output `ovf_count` [7:0], an 8-bit saturating count of dropped word pairs. It increments on every drop, saturates at 255, and is cleared by `overflow_clr` and by reset. When a drop coincides with `overflow_clr`, the count becomes 1.
  - **Undefined:** the port and the counter do not exist.

## Structure
- Package `pdm_pkg` holds:
  - `PDM_WORD_WIDTH_DEFAULT = 16`
  - an output-state enum `{PDM_OUT_EMPTY, PDM_OUT_FULL}`
  - `PDM_OVF_CNT_MAX = 8'd255`
- Sub-module `pdm_shift_packer` contains one channel's shift register and has ports `clk`, `reset`, `shift`, `din`, `word`. It is instantiated twice, and the parent owns the shared `bit_cnt`.

## Test plan
- **Basic packing:** W=16, 16 strobes with `q0` = 0xA5A5 and `q1` = 0x0F0F (MSB first), `ready` = 1 → one cycle after the 16th strobe, `data_ch0` = 0xA5A5, `data_ch1` = 0x0F0F and `valid` = 1 for exactly 1 cycle.
- **Backpressure drop:** `ready` = 0, two words sent (0x1234/0x5678, then 0xFFFF/0x0000) → output holds 0x1234/0x5678 and `overflow` = 1. With `PDM_DESER_OVF_CNT_EN`, `ovf_count` = 1.
- **Simultaneous accept and complete:** `ready` pulses in the same cycle a second word completes → `valid` stays 1, new data loads and `overflow` = 0.
- **Mid-word interruption:** after 7 strobes, assert `reset` (and in a separate run, drop `enable`) for 1 cycle, then send 16 strobes of 0xC3C3 → output 0xC3C3, with no stale bits from the partial word.
- **Clear vs set:** with `overflow` = 1, assert `overflow_clr` in the same cycle as a new drop → `overflow` stays 1. A clear alone in a later cycle → `overflow` = 0.
- **Counter saturation (macro on):** 300 drops → `ovf_count` = 255.
